// File: rtl/cpu_debug_slave_cmd_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_pkg
// Brief    : Shared IR codes, defaults and command record for the debug slave
// Revision : 1.0 - initial release
// ============================================================================
package cpu_debug_pkg;

    localparam int DEFAULT_IR_WIDTH   = 2;
    localparam int DEFAULT_SR_WIDTH   = 38;
    localparam int DEFAULT_ACTION_BIT = 37;

    localparam logic [DEFAULT_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [DEFAULT_IR_WIDTH-1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [DEFAULT_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
    localparam logic [DEFAULT_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

    typedef struct packed {
        logic [DEFAULT_IR_WIDTH-1:0] ir;
        logic [DEFAULT_SR_WIDTH-1:0] data;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/cpu_debug_slave_cmd_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_slave_cmd_queue_if
// Brief    : Ready/valid command stream from the queue to the OCI debug logic
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_debug_slave_cmd_queue_if
    import cpu_debug_pkg::*;
#(
    parameter int SR_WIDTH = DEFAULT_SR_WIDTH,
    parameter int IR_WIDTH = DEFAULT_IR_WIDTH
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [SR_WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_ir,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ir,
        input  cmd_data,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/cpu_debug_slave_cmd_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_cmd_fifo
// Brief    : Synchronous FIFO, power-of-2 depth, push+pop in one cycle allowed
// Revision : 1.0 - initial release
// ============================================================================
module cpu_debug_cmd_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             push_ok,
    output logic             pop_ok,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cpu_debug_slave_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_slave_cmd_queue
// Brief    : System-clock side of the CPU debug slave; queues update-DR commands
// Revision : 1.0 - initial release
// ============================================================================
module cpu_debug_slave_cmd_queue
    import cpu_debug_pkg::*;
#(
    parameter int  SR_WIDTH    = DEFAULT_SR_WIDTH,
    parameter int  IR_WIDTH    = DEFAULT_IR_WIDTH,
    parameter int  SYNC_STAGES = 2,
    parameter int  FIFO_DEPTH  = 4,
    parameter int  ACTION_BIT  = DEFAULT_ACTION_BIT,
    localparam int N_CMD       = 2 ** IR_WIDTH,
    localparam int LEVEL_W     = $clog2(FIFO_DEPTH) + 1
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [SR_WIDTH-1:0] sr,
    input  logic                vs_uir,
    input  logic                vs_udr,
    cpu_debug_slave_cmd_queue_if.master cmd,
    output logic [SR_WIDTH-1:0] jdo,
    output logic [N_CMD-1:0]    take_action,
    output logic [N_CMD-1:0]    take_no_action,
    output logic [LEVEL_W-1:0]  fifo_level,
    output logic                overrun,
    input  logic                overrun_clr
);
    logic [SYNC_STAGES-1:0]       uir_sync;
    logic [SYNC_STAGES-1:0]       udr_sync;
    logic                         uir_prev;
    logic                         udr_prev;
    logic                         uir_edge;
    logic                         udr_edge;
    logic [IR_WIDTH-1:0]          ir_q;
    logic [IR_WIDTH-1:0]          push_ir;
    logic [IR_WIDTH+SR_WIDTH-1:0] fifo_rdata;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic                         push_ok;
    logic                         pop_ok;

    // History resets high so a strobe already asserted at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync <= '1;
            udr_sync <= '1;
            uir_prev <= 1'b1;
            udr_prev <= 1'b1;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_prev <= uir_sync[SYNC_STAGES-1];
            udr_prev <= udr_sync[SYNC_STAGES-1];
        end
    end

    assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_prev;
    assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_prev;
    assign push_ir  = uir_edge ? ir_in : ir_q;

    cpu_debug_cmd_fifo #(
        .WIDTH (IR_WIDTH + SR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (udr_edge),
        .wdata   ({push_ir, sr}),
        .pop     (cmd.cmd_ready),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .push_ok (push_ok),
        .pop_ok  (pop_ok),
        .level   (fifo_level)
    );

    assign cmd.cmd_valid = ~fifo_empty;
    assign cmd.cmd_ir    = fifo_rdata[SR_WIDTH +: IR_WIDTH];
    assign cmd.cmd_data  = fifo_rdata[SR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q           <= '0;
            jdo            <= '0;
            overrun        <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            if (uir_edge) begin
                ir_q <= ir_in;
            end
            if (udr_edge) begin
                jdo <= sr;
            end
            if (udr_edge && !push_ok) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            take_action    <= '0;
            take_no_action <= '0;
            if (pop_ok) begin
                if (cmd.cmd_data[ACTION_BIT]) begin
                    take_action[cmd.cmd_ir] <= 1'b1;
                end else begin
                    take_no_action[cmd.cmd_ir] <= 1'b1;
                end
            end
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;
endmodule
`default_nettype wire
